averager_accumulator: RTL

Read-modify-write accumulation stage placed directly downstream of the averaging frame counter. For each valid sample it reads the running sum at the sample's word address from a dual-port block RAM. It then adds the sign-extended sample to that sum, or overwrites the sum on the first pass of a new average, and writes the result back. The pipeline is three stages deep with full hazard forwarding, so frames of any length, including one sample, accumulate correctly at one sample per clock.

---
 rtl/averager_accumulator.sv | 130 +++++++++++++
 1 files changed

// File: rtl/averager_accumulator.sv
// Read-modify-write accumulation stage: adds each signed sample into a running
// sum held in dual-port BRAM, with stage-2/stage-3 forwarding for back-to-back hits.
module averager_accumulator #(
    parameter int DATA_WIDTH = 14,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic                  s_first,
    output logic [ADDR_WIDTH-1:0] bram_rd_addr,
    input  logic [ACC_WIDTH-1:0]  bram_rd_data,
    output logic [ADDR_WIDTH-1:0] bram_wr_addr,
    output logic [ACC_WIDTH-1:0]  bram_wr_data,
    output logic [3:0]            bram_we,
    output logic                  busy
);

    localparam int WORD_WIDTH = ADDR_WIDTH - 2;

    logic                  s1_valid_r;
    logic [DATA_WIDTH-1:0] s1_data_r;
    logic [WORD_WIDTH-1:0] s1_word_r;
    logic                  s1_first_r;

    logic                  s2_valid_r;
    logic [WORD_WIDTH-1:0] s2_word_r;
    logic [ACC_WIDTH-1:0]  s2_sum_r;
    logic [3:0]            bram_we_r;

    logic                  s3_valid_r;
    logic [WORD_WIDTH-1:0] s3_word_r;
    logic [ACC_WIDTH-1:0]  s3_sum_r;

    logic                  busy_r;

    logic [ACC_WIDTH-1:0]  sample_ext_s;
    logic [ACC_WIDTH-1:0]  operand_s;
    logic [ACC_WIDTH-1:0]  base_s;
    logic [ACC_WIDTH-1:0]  sum_s;

    assign bram_rd_addr = s_addr;
    assign bram_wr_addr = {s2_word_r, 2'b00};
    assign bram_wr_data = s2_sum_r;
    assign bram_we      = bram_we_r;
    assign busy         = busy_r;

    // Stage 1 capture: sample, word index and overwrite flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {DATA_WIDTH{1'b0}};
            s1_word_r  <= {WORD_WIDTH{1'b0}};
            s1_first_r <= 1'b0;
        end else begin
            s1_valid_r <= s_valid;
            if (s_valid) begin
                s1_data_r  <= s_data;
                s1_word_r  <= s_addr[ADDR_WIDTH-1:2];
                s1_first_r <= s_first;
            end
        end
    end

    // Operand selection with forwarding, then add or overwrite
    always_comb begin
        sample_ext_s = ACC_WIDTH'($signed(s1_data_r));
        operand_s    = bram_rd_data;
        base_s       = {ACC_WIDTH{1'b0}};
        // Youngest in-flight write to the same word wins over older data and BRAM
        if (s2_valid_r && (s2_word_r == s1_word_r)) begin
            operand_s = s2_sum_r;
        end else if (s3_valid_r && (s3_word_r == s1_word_r)) begin
            operand_s = s3_sum_r;
        end else begin
            operand_s = bram_rd_data;
        end
        if (s1_first_r) begin
            base_s = {ACC_WIDTH{1'b0}};
        end else begin
            base_s = operand_s;
        end
        sum_s = base_s + sample_ext_s;
    end

    // Stage 2: write-back registers driving BRAM port B
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s2_valid_r <= 1'b0;
            s2_word_r  <= {WORD_WIDTH{1'b0}};
            s2_sum_r   <= {ACC_WIDTH{1'b0}};
            bram_we_r  <= 4'h0;
        end else begin
            s2_valid_r <= s1_valid_r;
            bram_we_r  <= s1_valid_r ? 4'hF : 4'h0;
            if (s1_valid_r) begin
                s2_word_r <= s1_word_r;
                s2_sum_r  <= sum_s;
            end
        end
    end

    // Stage 3: history of the write issued last cycle, covers BRAM write-to-read gap
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s3_valid_r <= 1'b0;
            s3_word_r  <= {WORD_WIDTH{1'b0}};
            s3_sum_r   <= {ACC_WIDTH{1'b0}};
        end else begin
            s3_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                s3_word_r <= s2_word_r;
                s3_sum_r  <= s2_sum_r;
            end
        end
    end

    // Busy mirrors the next-cycle occupancy of stages 1..3
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= s_valid | s1_valid_r | s2_valid_r;
        end
    end

endmodule
